// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and default width.
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_W = 2;
endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module seq_divider_step
  import seq_divider_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quot_i,
  input  logic [W-1:0] dreg_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quot_o
);
  // The compare runs at W+1 bits; the result is always below dreg, so W bits hold it.
  logic [W:0] s;
  logic       ge;

  assign s      = {rem_i, quot_i[W-1]};
  assign ge     = s >= {1'b0, dreg_i};
  assign rem_o  = ge ? (s[W-1:0] - dreg_i) : s[W-1:0];
  assign quot_o = {quot_i[W-2:0], ge};
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SELFCHECK_EN to add the Q*D+R==N, R<D result check driving ERR.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] N,
  input  logic [W-1:0] D,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         DIV0,
  output logic         ERR
);
  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_q;
  logic [W-1:0]  rem_q, quot_q, dreg_q, q_q, r_q;
  logic [W-1:0]  rem_d, quot_d;
  logic [CW-1:0] count_q;
  logic          div0_q, err_q, err_d;

  seq_divider_step #(.W(W)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dreg_i (dreg_q),
    .rem_o  (rem_d),
    .quot_o (quot_d)
  );

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  logic [W-1:0]   n_q;
  logic [2*W-1:0] prod;

  always_ff @(posedge CLK) begin
    if (RST)                                         n_q <= '0;
    else if (state_q == IDLE && IN_VALID && D != '0) n_q <= N;
  end

  // Judged on the values about to be latched, so ERR lands together with Q/R.
  assign prod  = ({{W{1'b0}}, quot_d} * {{W{1'b0}}, dreg_q}) + {{W{1'b0}}, rem_d};
  assign err_d = (prod != {{W{1'b0}}, n_q}) || (rem_d >= dreg_q);
`else
  assign err_d = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quot_q  <= '0;
      dreg_q  <= '0;
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (IN_VALID) begin
          if (D != '0) begin
            quot_q  <= N;
            rem_q   <= '0;
            dreg_q  <= D;
            count_q <= CNT_LAST;
            state_q <= BUSY;
          end else begin
            q_q     <= '1;
            r_q     <= N;
            div0_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        BUSY: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          if (count_q == '0) begin
            q_q     <= quot_d;
            r_q     <= rem_d;
            div0_q  <= 1'b0;
            err_q   <= err_d;
            state_q <= DONE;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        DONE: if (OUT_READY) begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign DIV0      = div0_q;
  assign ERR       = err_q;
endmodule
